// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//
// Initiator side of the data memory port. Takes one load/store request at a
// time from the MEM stage and drives a word-granular memory port (combinational
// read while mem_read_o is high, whole-word write on the clock edge while
// mem_write_o is high). Loads are sign/zero-extended; byte and halfword stores
// are done as read-modify-write of the containing word.
//
// Optional feature macro: MISALIGN_TRAP_EN
//   defined   : misaligned half/word and reserved size go straight to RESP
//               with resp_err_o=1 and no memory access.
//   undefined : resp_err_o tied 0, misaligned addresses forced to alignment,
//               reserved size handled as word.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   req_valid_i/ready_o   request handshake (ready only when idle)
//   req_we_i              1 = store, 0 = load
//   req_size_i            00 byte, 01 half, 10 word, 11 reserved
//   req_unsigned_i        loads: 1 = zero-extend, 0 = sign-extend
//   req_addr_i            byte address
//   req_wdata_i           store data, right-justified
//   resp_valid_o          one-cycle completion pulse
//   resp_data_o           load result (0 for stores)
//   resp_err_o            misaligned/reserved error
//   mem_addr_o            word-aligned memory address (modulo MEM_BYTES)
//   mem_wdata_o           memory write data
//   mem_write_o           MemWrite
//   mem_read_o            MemRead
//   mem_rdata_i           memory read data (combinational)
// -----------------------------------------------------------------------------
module load_store_unit #(
   parameter int ADDR_WIDTH = 32,
   parameter int MEM_BYTES  = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  req_valid_i,
   output logic                  req_ready_o,
   input  logic                  req_we_i,
   input  logic [1:0]            req_size_i,
   input  logic                  req_unsigned_i,
   input  logic [ADDR_WIDTH-1:0] req_addr_i,
   input  logic [31:0]           req_wdata_i,
   output logic                  resp_valid_o,
   output logic [31:0]           resp_data_o,
   output logic                  resp_err_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   output logic [31:0]           mem_wdata_o,
   output logic                  mem_write_o,
   output logic                  mem_read_o,
   input  logic [31:0]           mem_rdata_i
);

   typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_RESP} state_t;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_RSVD = 2'b11;

   // Keeps the in-memory byte offset and drops the two byte-lane bits.
   localparam logic [ADDR_WIDTH-1:0] WORD_MASK =
      ADDR_WIDTH'(MEM_BYTES - 1) & ~ADDR_WIDTH'(3);

   state_t      state;
   logic        lat_we;
   logic [1:0]  lat_size;
   logic        lat_unsigned;
   logic [1:0]  lat_off;
   logic [31:0] lat_wdata;

   // Request decode at accept time: effective size and lane offset.
   logic [1:0]  acc_size;
   logic [1:0]  acc_off;
`ifdef MISALIGN_TRAP_EN
   logic        acc_misaligned;
`endif

   // NOTE: every signal written in always_comb gets a default first, so no
   // path through the case statements can leave it unassigned (no latch).
   always_comb begin
      acc_size = req_size_i;
      acc_off  = req_addr_i[1:0];
`ifdef MISALIGN_TRAP_EN
      acc_misaligned = 1'b0;
      case (req_size_i)
         SZ_HALF: acc_misaligned = req_addr_i[0];
         SZ_WORD: acc_misaligned = |req_addr_i[1:0];
         SZ_RSVD: acc_misaligned = 1'b1;
         default: acc_misaligned = 1'b0;
      endcase
`else
      if (req_size_i == SZ_RSVD) acc_size = SZ_WORD;
      case (acc_size)
         SZ_HALF: acc_off[0] = 1'b0;
         SZ_WORD: acc_off    = 2'b00;
         default: ;
      endcase
`endif
   end

   // Lane extraction and merge on the word returned during RD.
   logic [4:0]  byte_shift;
   logic [4:0]  half_shift;
   logic [7:0]  byte_lane;
   logic [15:0] half_lane;
   logic [31:0] load_data;
   logic [31:0] merged_data;

   always_comb begin
      byte_shift = {lat_off, 3'b000};
      half_shift = {lat_off[1], 4'b0000};
      byte_lane  = 8'(mem_rdata_i >> byte_shift);
      half_lane  = lat_off[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
      case (lat_size)
         SZ_BYTE: begin
            load_data   = {{24{~lat_unsigned & byte_lane[7]}}, byte_lane};
            merged_data = (mem_rdata_i & ~(32'h0000_00FF << byte_shift))
                        | ({24'h0, lat_wdata[7:0]} << byte_shift);
         end
         SZ_HALF: begin
            load_data   = {{16{~lat_unsigned & half_lane[15]}}, half_lane};
            merged_data = (mem_rdata_i & ~(32'h0000_FFFF << half_shift))
                        | ({16'h0, lat_wdata[15:0]} << half_shift);
         end
         default: begin
            load_data   = mem_rdata_i;
            merged_data = lat_wdata;
         end
      endcase
   end

   // Ready is forced low during reset so nothing can be accepted then.
   assign req_ready_o = (state == S_IDLE) && !rst_i;

`ifndef MISALIGN_TRAP_EN
   assign resp_err_o = 1'b0;
`endif

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples pre-edge values regardless of statement order.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state        <= S_IDLE;
         lat_we       <= 1'b0;
         lat_size     <= SZ_BYTE;
         lat_unsigned <= 1'b0;
         lat_off      <= 2'b00;
         lat_wdata    <= 32'h0;
         resp_valid_o <= 1'b0;
         resp_data_o  <= 32'h0;
`ifdef MISALIGN_TRAP_EN
         resp_err_o   <= 1'b0;
`endif
         mem_addr_o   <= '0;
         mem_wdata_o  <= 32'h0;
         mem_write_o  <= 1'b0;
         mem_read_o   <= 1'b0;
      end else begin
         // Strobes are single-cycle unless a state re-asserts them.
         resp_valid_o <= 1'b0;
         resp_data_o  <= 32'h0;
`ifdef MISALIGN_TRAP_EN
         resp_err_o   <= 1'b0;
`endif
         mem_write_o  <= 1'b0;
         mem_read_o   <= 1'b0;

         case (state)
            S_IDLE: begin
               if (req_valid_i) begin
                  lat_we       <= req_we_i;
                  lat_size     <= acc_size;
                  lat_unsigned <= req_unsigned_i;
                  lat_off      <= acc_off;
                  lat_wdata    <= req_wdata_i;
                  mem_addr_o   <= req_addr_i & WORD_MASK;
`ifdef MISALIGN_TRAP_EN
                  if (acc_misaligned) begin
                     state        <= S_RESP;
                     resp_valid_o <= 1'b1;
                     resp_err_o   <= 1'b1;
                  end else
`endif
                  if (req_we_i && acc_size == SZ_WORD) begin
                     state       <= S_WR;
                     mem_write_o <= 1'b1;
                     mem_wdata_o <= req_wdata_i;
                  end else begin
                     state      <= S_RD;
                     mem_read_o <= 1'b1;
                  end
               end
            end

            S_RD: begin
               if (lat_we) begin
                  state       <= S_WR;
                  mem_write_o <= 1'b1;
                  mem_wdata_o <= merged_data;
               end else begin
                  state        <= S_RESP;
                  resp_valid_o <= 1'b1;
                  resp_data_o  <= load_data;
               end
            end

            S_WR: begin
               state        <= S_RESP;
               resp_valid_o <= 1'b1;
            end

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit
//
// Directed bench for load_store_unit with a small word memory model on the
// memory port. Each scenario task drives one request and compares the per-cycle
// trace of the DUT outputs with hand-computed values.
// -----------------------------------------------------------------------------
module tb_load_store_unit;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        req_valid_i = 1'b0;
   logic        req_ready_o;
   logic        req_we_i = 1'b0;
   logic [1:0]  req_size_i = 2'b00;
   logic        req_unsigned_i = 1'b0;
   logic [31:0] req_addr_i = 32'h0;
   logic [31:0] req_wdata_i = 32'h0;
   logic        resp_valid_o;
   logic [31:0] resp_data_o;
   logic        resp_err_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_wdata_o;
   logic        mem_write_o;
   logic        mem_read_o;
   logic [31:0] mem_rdata_i;

   int pass_cnt = 0;
   int total_cnt = 0;

   load_store_unit #(.ADDR_WIDTH(32), .MEM_BYTES(32)) dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .req_valid_i    (req_valid_i),
      .req_ready_o    (req_ready_o),
      .req_we_i       (req_we_i),
      .req_size_i     (req_size_i),
      .req_unsigned_i (req_unsigned_i),
      .req_addr_i     (req_addr_i),
      .req_wdata_i    (req_wdata_i),
      .resp_valid_o   (resp_valid_o),
      .resp_data_o    (resp_data_o),
      .resp_err_o     (resp_err_o),
      .mem_addr_o     (mem_addr_o),
      .mem_wdata_o    (mem_wdata_o),
      .mem_write_o    (mem_write_o),
      .mem_read_o     (mem_read_o),
      .mem_rdata_i    (mem_rdata_i)
   );

   always #5 clk_i = ~clk_i;

   // 32-byte little-endian memory held as 8 words.
   logic [31:0] mem_words [0:7];
   logic        pl_en = 1'b0;
   logic [2:0]  pl_idx = 3'd0;
   logic [31:0] pl_data = 32'h0;
   logic [2:0]  mem_idx;

   assign mem_idx     = 3'((mem_addr_o >> 2) & 32'h7);
   assign mem_rdata_i = mem_read_o ? mem_words[mem_idx] : 32'h0;

   always @(posedge clk_i) begin
      if (mem_write_o) mem_words[mem_idx] <= mem_wdata_o;
      else if (pl_en)  mem_words[pl_idx]  <= pl_data;
   end

   // Per-cycle trace after the accept edge; index k = cycle N+k.
   logic [5:1]  tr_rd, tr_wr, tr_rv, tr_err, tr_rdy;
   logic [31:0] tr_data  [1:5];
   logic [31:0] tr_addr  [1:5];
   logic [31:0] tr_wdata [1:5];

   task automatic preload(input logic [2:0] idx, input logic [31:0] data);
      @(negedge clk_i);
      pl_en = 1'b1; pl_idx = idx; pl_data = data;
      @(negedge clk_i);
      pl_en = 1'b0;
   endtask

   task automatic run_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata);
      @(negedge clk_i);
      req_valid_i = 1'b1; req_we_i = we; req_size_i = size;
      req_unsigned_i = uns; req_addr_i = addr; req_wdata_i = wdata;
      total_cnt++;
      if (req_ready_o !== 1'b1) $display("FAIL accept_ready addr=%h: got %b expected 1", addr, req_ready_o);
      else pass_cnt++;
      @(posedge clk_i);
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk_i);
         tr_rd[k] = mem_read_o;   tr_wr[k] = mem_write_o;
         tr_rv[k] = resp_valid_o; tr_err[k] = resp_err_o;
         tr_rdy[k] = req_ready_o;
         tr_data[k] = resp_data_o; tr_addr[k] = mem_addr_o; tr_wdata[k] = mem_wdata_o;
         // Valid stays high during N+1 to show it is ignored while busy.
         if (k == 1) req_valid_i = 1'b0;
      end
   endtask

   task automatic test_reset;
      @(negedge clk_i);
      total_cnt++;
      if ({req_ready_o, resp_valid_o, resp_err_o, mem_write_o, mem_read_o} !== 5'b0 ||
          resp_data_o !== 32'h0 || mem_addr_o !== 32'h0 || mem_wdata_o !== 32'h0)
         $display("FAIL reset_outputs: got rdy=%b rv=%b err=%b wr=%b rd=%b data=%h addr=%h wdata=%h expected all 0",
                  req_ready_o, resp_valid_o, resp_err_o, mem_write_o, mem_read_o, resp_data_o, mem_addr_o, mem_wdata_o);
      else pass_cnt++;
      rst_i = 1'b0;
      @(negedge clk_i);
      total_cnt++;
      if (req_ready_o !== 1'b1) $display("FAIL reset_release_ready: got %b expected 1", req_ready_o);
      else pass_cnt++;
   endtask

   task automatic test_word_store;
      run_req(1'b1, 2'b10, 1'b0, 32'h04, 32'h0000_000A);
      total_cnt++;
      if (tr_wr !== 5'b00001 || tr_rd !== 5'b00000 || tr_rv !== 5'b00010)
         $display("FAIL word_store_timing: got wr=%b rd=%b rv=%b expected 00001 00000 00010", tr_wr, tr_rd, tr_rv);
      else pass_cnt++;
      total_cnt++;
      if (tr_addr[1] !== 32'h04 || tr_wdata[1] !== 32'h0000_000A)
         $display("FAIL word_store_port: got addr=%h wdata=%h expected 00000004 0000000a", tr_addr[1], tr_wdata[1]);
      else pass_cnt++;
      total_cnt++;
      if (mem_words[1] !== 32'h0000_000A || tr_data[2] !== 32'h0 || tr_err !== 5'b0)
         $display("FAIL word_store_mem: got mem=%h data=%h err=%b expected 0000000a 00000000 00000", mem_words[1], tr_data[2], tr_err);
      else pass_cnt++;
      total_cnt++;
      if (tr_rdy !== 5'b11100) $display("FAIL word_store_ready: got %b expected 11100", tr_rdy);
      else pass_cnt++;
   endtask

   task automatic test_byte_store;
      preload(3'd2, 32'h1122_3344);
      run_req(1'b1, 2'b00, 1'b0, 32'h09, 32'h0000_00FF);
      total_cnt++;
      if (tr_rd !== 5'b00001 || tr_wr !== 5'b00010 || tr_rv !== 5'b00100)
         $display("FAIL byte_store_timing: got rd=%b wr=%b rv=%b expected 00001 00010 00100", tr_rd, tr_wr, tr_rv);
      else pass_cnt++;
      total_cnt++;
      if (tr_addr[1] !== 32'h08 || tr_wdata[2] !== 32'h1122_FF44)
         $display("FAIL byte_store_merge: got addr=%h wdata=%h expected 00000008 1122ff44", tr_addr[1], tr_wdata[2]);
      else pass_cnt++;
      total_cnt++;
      if (mem_words[2] !== 32'h1122_FF44) $display("FAIL byte_store_mem: got %h expected 1122ff44", mem_words[2]);
      else pass_cnt++;
   endtask

   task automatic test_half_store;
      preload(3'd3, 32'hDEAD_BEEF);
      run_req(1'b1, 2'b01, 1'b0, 32'h0E, 32'hFFFF_1234);
      total_cnt++;
      if (tr_wr !== 5'b00010 || mem_words[3] !== 32'h1234_BEEF)
         $display("FAIL half_store: got wr=%b mem=%h expected 00010 1234beef", tr_wr, mem_words[3]);
      else pass_cnt++;
   endtask

   task automatic test_byte_load;
      run_req(1'b0, 2'b00, 1'b0, 32'h09, 32'h0);
      total_cnt++;
      if (tr_rd !== 5'b00001 || tr_wr !== 5'b00000 || tr_rv !== 5'b00010)
         $display("FAIL byte_load_timing: got rd=%b wr=%b rv=%b expected 00001 00000 00010", tr_rd, tr_wr, tr_rv);
      else pass_cnt++;
      total_cnt++;
      if (tr_data[2] !== 32'hFFFF_FFFF) $display("FAIL byte_load_signed: got %h expected ffffffff", tr_data[2]);
      else pass_cnt++;
      run_req(1'b0, 2'b00, 1'b1, 32'h09, 32'h0);
      total_cnt++;
      if (tr_data[2] !== 32'h0000_00FF || tr_wr !== 5'b0)
         $display("FAIL byte_load_unsigned: got data=%h wr=%b expected 000000ff 00000", tr_data[2], tr_wr);
      else pass_cnt++;
      run_req(1'b0, 2'b00, 1'b1, 32'h0B, 32'h0);
      total_cnt++;
      if (tr_data[2] !== 32'h0000_0011) $display("FAIL byte_load_lane3: got %h expected 00000011", tr_data[2]);
      else pass_cnt++;
   endtask

   task automatic test_half_load;
      preload(3'd2, 32'h8000_FF44);
      run_req(1'b0, 2'b01, 1'b0, 32'h0A, 32'h0);
      total_cnt++;
      if (tr_data[2] !== 32'hFFFF_8000 || tr_rv !== 5'b00010)
         $display("FAIL half_load_signed: got data=%h rv=%b expected ffff8000 00010", tr_data[2], tr_rv);
      else pass_cnt++;
      run_req(1'b0, 2'b01, 1'b1, 32'h0A, 32'h0);
      total_cnt++;
      if (tr_data[2] !== 32'h0000_8000) $display("FAIL half_load_unsigned: got %h expected 00008000", tr_data[2]);
      else pass_cnt++;
      run_req(1'b0, 2'b01, 1'b0, 32'h08, 32'h0);
      total_cnt++;
      if (tr_data[2] !== 32'hFFFF_FF44) $display("FAIL half_load_low: got %h expected ffffff44", tr_data[2]);
      else pass_cnt++;
   endtask

   task automatic test_wrap;
      // 0x24 modulo 32 is word 0x04, which holds 0x0000000A.
      run_req(1'b0, 2'b10, 1'b0, 32'h24, 32'h0);
      total_cnt++;
      if (tr_addr[1] !== 32'h04 || tr_data[2] !== 32'h0000_000A)
         $display("FAIL addr_wrap: got addr=%h data=%h expected 00000004 0000000a", tr_addr[1], tr_data[2]);
      else pass_cnt++;
   endtask

   task automatic test_misaligned;
      run_req(1'b0, 2'b10, 1'b0, 32'h06, 32'h0);
`ifdef MISALIGN_TRAP_EN
      total_cnt++;
      if (tr_rv !== 5'b00001 || tr_err !== 5'b00001 || tr_rd !== 5'b0 || tr_data[1] !== 32'h0)
         $display("FAIL misaligned_trap: got rv=%b err=%b rd=%b data=%h expected 00001 00001 00000 00000000",
                  tr_rv, tr_err, tr_rd, tr_data[1]);
      else pass_cnt++;
`else
      total_cnt++;
      if (tr_rd !== 5'b00001 || tr_addr[1] !== 32'h04 || tr_data[2] !== 32'h0000_000A || tr_err !== 5'b0)
         $display("FAIL misaligned_forced: got rd=%b addr=%h data=%h err=%b expected 00001 00000004 0000000a 00000",
                  tr_rd, tr_addr[1], tr_data[2], tr_err);
      else pass_cnt++;
`endif
      run_req(1'b1, 2'b11, 1'b0, 32'h1C, 32'h1234_5678);
`ifdef MISALIGN_TRAP_EN
      total_cnt++;
      if (tr_rv !== 5'b00001 || tr_err !== 5'b00001 || tr_wr !== 5'b0)
         $display("FAIL reserved_trap: got rv=%b err=%b wr=%b expected 00001 00001 00000", tr_rv, tr_err, tr_wr);
      else pass_cnt++;
`else
      total_cnt++;
      if (tr_wr !== 5'b00001 || tr_rv !== 5'b00010 || mem_words[7] !== 32'h1234_5678)
         $display("FAIL reserved_as_word: got wr=%b rv=%b mem=%h expected 00001 00010 12345678", tr_wr, tr_rv, mem_words[7]);
      else pass_cnt++;
`endif
   endtask

   task automatic test_reset_abort;
      preload(3'd4, 32'hAABB_CCDD);
      @(negedge clk_i);
      req_valid_i = 1'b1; req_we_i = 1'b1; req_size_i = 2'b00;
      req_unsigned_i = 1'b0; req_addr_i = 32'h10; req_wdata_i = 32'h0000_0055;
      @(posedge clk_i);
      @(negedge clk_i);                       // N+1: RD
      req_valid_i = 1'b0;
      total_cnt++;
      if (mem_read_o !== 1'b1) $display("FAIL abort_rd_cycle: got %b expected 1", mem_read_o);
      else pass_cnt++;
      rst_i = 1'b1;
      @(negedge clk_i);                       // N+2: in reset
      total_cnt++;
      if (mem_write_o !== 1'b0 || req_ready_o !== 1'b0)
         $display("FAIL abort_in_reset: got wr=%b rdy=%b expected 0 0", mem_write_o, req_ready_o);
      else pass_cnt++;
      rst_i = 1'b0;
      @(negedge clk_i);                       // N+3: released
      total_cnt++;
      if (req_ready_o !== 1'b1 || mem_write_o !== 1'b0 || mem_words[4] !== 32'hAABB_CCDD)
         $display("FAIL abort_after_reset: got rdy=%b wr=%b mem=%h expected 1 0 aabbccdd",
                  req_ready_o, mem_write_o, mem_words[4]);
      else pass_cnt++;
   endtask

   task automatic test_back_to_back;
      @(negedge clk_i);
      req_valid_i = 1'b1; req_we_i = 1'b1; req_size_i = 2'b10;
      req_unsigned_i = 1'b0; req_addr_i = 32'h14; req_wdata_i = 32'hCAFE_F00D;
      @(posedge clk_i);
      @(negedge clk_i);                       // N+1: WR
      req_valid_i = 1'b0;
      @(negedge clk_i);                       // N+2: RESP, load offered while busy
      total_cnt++;
      if (resp_valid_o !== 1'b1 || req_ready_o !== 1'b0)
         $display("FAIL b2b_resp: got rv=%b rdy=%b expected 1 0", resp_valid_o, req_ready_o);
      else pass_cnt++;
      req_valid_i = 1'b1; req_we_i = 1'b0; req_addr_i = 32'h14; req_wdata_i = 32'h0;
      @(negedge clk_i);                       // N+3: idle, load accepted here
      total_cnt++;
      if (req_ready_o !== 1'b1 || mem_read_o !== 1'b0)
         $display("FAIL b2b_ready: got rdy=%b rd=%b expected 1 0", req_ready_o, mem_read_o);
      else pass_cnt++;
      @(negedge clk_i);                       // N+4: RD of the load
      req_valid_i = 1'b0;
      total_cnt++;
      if (mem_read_o !== 1'b1 || mem_addr_o !== 32'h14)
         $display("FAIL b2b_rd: got rd=%b addr=%h expected 1 00000014", mem_read_o, mem_addr_o);
      else pass_cnt++;
      @(negedge clk_i);                       // N+5: load response
      total_cnt++;
      if (resp_valid_o !== 1'b1 || resp_data_o !== 32'hCAFE_F00D)
         $display("FAIL b2b_load_data: got rv=%b data=%h expected 1 cafef00d", resp_valid_o, resp_data_o);
      else pass_cnt++;
      @(negedge clk_i);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clk_i);
      test_reset;
      test_word_store;
      test_byte_store;
      test_half_store;
      test_byte_load;
      test_half_load;
      test_wrap;
      test_misaligned;
      test_reset_abort;
      test_back_to_back;
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
